// File: rtl/slurm16_input_conditioner.sv
// rtl/slurm16_input_conditioner.sv - PLL-qualified reset sequencer plus N-channel debounce and edge/event logic
module slurm16_input_conditioner #(
   parameter int                    NUM_INPUTS        = 6,
   parameter int                    DEBOUNCE_CYCLES   = 250000,
   parameter int                    RESET_HOLD_CYCLES = 10000,
   parameter logic [NUM_INPUTS-1:0] INVERT_MASK       = {NUM_INPUTS{1'b1}},
   parameter int                    EDGE_MODE         = 0
) (
   input  logic                  clk,
   input  logic                  RSTb,
   input  logic                  pll_locked,
   output logic                  core_rstb,
   input  logic [NUM_INPUTS-1:0] pin_in,
   output logic [NUM_INPUTS-1:0] in_stable,
   output logic [NUM_INPUTS-1:0] rise_pulse,
   output logic [NUM_INPUTS-1:0] fall_pulse,
   output logic [NUM_INPUTS-1:0] event_flags,
   input  logic [NUM_INPUTS-1:0] clear_flags,
   output logic                  irq
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_HOLD_CYCLES);

   logic          lock_s1;
   logic          lock_s2;
   logic [HW-1:0] hold_cnt;

   // Any loss of lock restarts the whole hold period; the counter saturates once released.
   always_ff @(posedge clk or negedge RSTb) begin
      if (!RSTb) begin
         lock_s1   <= 1'b0;
         lock_s2   <= 1'b0;
         hold_cnt  <= '0;
         core_rstb <= 1'b0;
      end else begin
         lock_s1 <= pll_locked;
         lock_s2 <= lock_s1;
         if (!lock_s2) begin
            hold_cnt  <= '0;
            core_rstb <= 1'b0;
         end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt  <= hold_cnt + 1'b1;
            core_rstb <= (hold_cnt == HOLD_MAX - 1'b1);
         end
      end
   end

   logic [NUM_INPUTS-1:0] sync1;
   logic [NUM_INPUTS-1:0] sync2;
   logic [NUM_INPUTS-1:0] sample;
   logic [DW-1:0]         db_cnt [NUM_INPUTS];

   // Synchronisers reset to the idle pin level so the logical level starts at 0.
   assign sample = sync2 ^ INVERT_MASK;

   always_ff @(posedge clk or negedge RSTb) begin
      if (!RSTb) begin
         sync1      <= INVERT_MASK;
         sync2      <= INVERT_MASK;
         in_stable  <= '0;
         rise_pulse <= '0;
         fall_pulse <= '0;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1 <= pin_in;
         sync2 <= sync1;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            rise_pulse[i] <= 1'b0;
            fall_pulse[i] <= 1'b0;
            if (sample[i] == in_stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               in_stable[i]  <= sample[i];
               db_cnt[i]     <= '0;
               rise_pulse[i] <= sample[i];
               fall_pulse[i] <= ~sample[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   logic [NUM_INPUTS-1:0] event_set;

   always_comb begin
      event_set = '0;
      case (EDGE_MODE)
         0:       event_set = rise_pulse;
         1:       event_set = fall_pulse;
         default: event_set = rise_pulse | fall_pulse;
      endcase
   end

   // Set has priority over clear so an event arriving with a clear strobe is kept.
   always_ff @(posedge clk or negedge RSTb) begin
      if (!RSTb) begin
         event_flags <= '0;
      end else begin
         event_flags <= (event_flags & ~clear_flags) | event_set;
      end
   end

   assign irq = |event_flags;

endmodule
